// File: rtl/ga_pkg.sv
// ============================================================================
// Module   : ga_pkg
// Purpose  : Shared types and default widths for the GA stop controller.
// Revision : 1.0
// ============================================================================
`default_nettype none

package ga_pkg;

    localparam int FITNESS_WIDTH_D = 27;
    localparam int CHROM_WIDTH_D   = 8;

    typedef enum logic [2:0] {
        SR_NONE   = 3'd0,
        SR_TARGET = 3'd1,
        SR_MAXGEN = 3'd2,
        SR_STALL  = 3'd3,
        SR_ABORT  = 3'd4
    } stop_reason_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } ga_stop_state_e;

endpackage

`default_nettype wire

// File: rtl/ga_stop_ctrl_sat_counter.sv
// ============================================================================
// Module   : sat_counter
// Purpose  : Clearable up-counter that sticks at all ones; also exposes its
//            next value so callers can make decisions on post-update counts.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] count_next
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Clear dominates increment.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count      = count_q;
    assign count_next = count_d;

endmodule

`default_nettype wire

// File: rtl/ga_stop_ctrl.sv
// ============================================================================
// Module   : ga_stop_ctrl
// Purpose  : GA run supervisor: clears the best tracker, samples its result
//            each generation and decides termination. Option: GA_STOP_ABORT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ga_stop_ctrl
    import ga_pkg::*;
#(
    parameter int FITNESS_WIDTH = FITNESS_WIDTH_D,
    parameter int CHROM_WIDTH   = CHROM_WIDTH_D,
    parameter int GEN_WIDTH     = 16,
    parameter int STALL_WIDTH   = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
`ifdef GA_STOP_ABORT_EN
    input  logic                     abort,
`endif
    input  logic                     gen_done,
    input  logic [FITNESS_WIDTH-1:0] best_fit,
    input  logic [CHROM_WIDTH-1:0]   best,
    input  logic [FITNESS_WIDTH-1:0] target_fit,
    input  logic [GEN_WIDTH-1:0]     max_gens,
    input  logic [STALL_WIDTH-1:0]   stall_limit,
    output logic                     clear_best,
    output logic                     running,
    output logic                     done,
    output logic [2:0]               stop_reason,
    output logic [GEN_WIDTH-1:0]     gen_count,
    output logic [STALL_WIDTH-1:0]   stall_count,
    output logic [FITNESS_WIDTH-1:0] result_fit,
    output logic [CHROM_WIDTH-1:0]   result_chrom
);

    ga_stop_state_e             state_q, state_d;
    stop_reason_e               reason_q, reason_d;
    logic                       clear_best_q, clear_best_d;
    logic                       running_q, running_d;
    logic                       done_q, done_d;
    logic [FITNESS_WIDTH-1:0]   result_fit_q, result_fit_d;
    logic [CHROM_WIDTH-1:0]     result_chrom_q, result_chrom_d;

    logic                       abort_req;
    logic                       in_clear;
    logic                       run_gen;
    logic                       improved;
    logic                       hit_target;
    logic                       hit_maxgen;
    logic                       hit_stall;
    logic [GEN_WIDTH-1:0]       gen_next;
    logic [STALL_WIDTH-1:0]     stall_next;

`ifdef GA_STOP_ABORT_EN
    assign abort_req = abort && (state_q == ST_RUN);
`else
    assign abort_req = 1'b0;
`endif

    // An aborted cycle must not count as a generation even if gen_done is set.
    assign in_clear   = (state_q == ST_CLEAR);
    assign run_gen    = (state_q == ST_RUN) && gen_done && !abort_req;
    assign improved   = (best_fit < result_fit_q);

    sat_counter #(
        .WIDTH      (GEN_WIDTH)
    ) u_gen_cnt (
        .clk        (clk),
        .reset      (reset),
        .clr        (in_clear),
        .inc        (run_gen),
        .count      (gen_count),
        .count_next (gen_next)
    );

    sat_counter #(
        .WIDTH      (STALL_WIDTH)
    ) u_stall_cnt (
        .clk        (clk),
        .reset      (reset),
        .clr        (in_clear || (run_gen && improved)),
        .inc        (run_gen && !improved),
        .count      (stall_count),
        .count_next (stall_next)
    );

    assign hit_target = (best_fit <= target_fit);
    assign hit_maxgen = (max_gens != '0) && (gen_next == max_gens);
    assign hit_stall  = (stall_limit != '0) && (stall_next >= stall_limit);

    always_comb begin
        state_d        = state_q;
        reason_d       = reason_q;
        result_fit_d   = result_fit_q;
        result_chrom_d = result_chrom_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                state_d      = ST_RUN;
                reason_d     = SR_NONE;
                result_fit_d = {FITNESS_WIDTH{1'b1}};
            end
            ST_RUN: begin
                if (abort_req) begin
                    state_d  = ST_DONE;
                    reason_d = SR_ABORT;
                end else if (gen_done) begin
                    if (improved) begin
                        result_fit_d   = best_fit;
                        result_chrom_d = best;
                    end
                    if (hit_target) begin
                        state_d  = ST_DONE;
                        reason_d = SR_TARGET;
                    end else if (hit_maxgen) begin
                        state_d  = ST_DONE;
                        reason_d = SR_MAXGEN;
                    end else if (hit_stall) begin
                        state_d  = ST_DONE;
                        reason_d = SR_STALL;
                    end
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_d = ST_CLEAR;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Status outputs are registered from the next state so they line up with it.
        clear_best_d = (state_d == ST_CLEAR);
        running_d    = (state_d == ST_RUN);
        done_d       = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            reason_q       <= SR_NONE;
            clear_best_q   <= 1'b0;
            running_q      <= 1'b0;
            done_q         <= 1'b0;
            result_fit_q   <= {FITNESS_WIDTH{1'b1}};
            result_chrom_q <= '0;
        end else begin
            state_q        <= state_d;
            reason_q       <= reason_d;
            clear_best_q   <= clear_best_d;
            running_q      <= running_d;
            done_q         <= done_d;
            result_fit_q   <= result_fit_d;
            result_chrom_q <= result_chrom_d;
        end
    end

    assign clear_best   = clear_best_q;
    assign running      = running_q;
    assign done         = done_q;
    assign stop_reason  = reason_q;
    assign result_fit   = result_fit_q;
    assign result_chrom = result_chrom_q;

endmodule

`default_nettype wire

// File: doc/ga_stop_ctrl.md
Name: ga_stop_ctrl

Overview:
- Generation-level supervisor that sits directly downstream of the best-tracker stage.
- Clears the tracker at run start and samples its running-minimum best_fit/best at each end-of-generation strobe.
- Keeps the overall result, generation count and stall count.
- Decides when the GA run terminates: target reached, generation limit, or stagnation.

Parameters:
- FITNESS_WIDTH, 27, width of fitness values (lower is better)
- CHROM_WIDTH, 8, width of a chromosome
- GEN_WIDTH, 16, width of generation counter and max_gens
- STALL_WIDTH, 8, width of stall counter and stall_limit

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins a run from IDLE or DONE
- gen_done  in  1  one-cycle pulse; best_fit/best are valid for the generation just finished
- best_fit  in  FITNESS_WIDTH  tracker's current minimum fitness
- best  in  CHROM_WIDTH  tracker's chromosome for best_fit
- target_fit  in  FITNESS_WIDTH  stop when best_fit <= target_fit
- max_gens  in  GEN_WIDTH  generation limit; 0 = unlimited
- stall_limit  in  STALL_WIDTH  generations without improvement before stopping; 0 = disabled
- clear_best  out  1  one-cycle pulse; drives the tracker's synchronous active-high clear
- running  out  1  high in RUN
- done  out  1  high in DONE
- stop_reason  out  3  0 NONE, 1 TARGET, 2 MAXGEN, 3 STALL, 4 ABORT
- gen_count  out  GEN_WIDTH  generations completed this run
- stall_count  out  STALL_WIDTH  consecutive non-improving generations
- result_fit  out  FITNESS_WIDTH  best fitness of the run
- result_chrom  out  CHROM_WIDTH  chromosome for result_fit

Behaviour:
- Reset (async, reset=0):
  - state IDLE; clear_best, running and done are 0.
  - stop_reason NONE; gen_count 0; stall_count 0.
  - result_fit all ones; result_chrom 0.
- IDLE:
  - start -> CLEAR.
  - gen_done is ignored.
- CLEAR (exactly 1 cycle):
  - clear_best=1.
  - gen_count, stall_count <= 0; result_fit <= all ones; stop_reason <= NONE.
  - Unconditionally -> RUN.
- RUN, gen_done=1 (all updates registered on that edge):
  - gen_count <= gen_count+1, saturating at all ones.
  - improved = (best_fit < result_fit), strict compare.
  - If improved: result_fit <= best_fit, result_chrom <= best, stall_count <= 0.
  - Otherwise stall_count <= stall_count+1, saturating.
  - Stop checks use post-update values, priority TARGET > MAXGEN > STALL:
    - TARGET if best_fit <= target_fit.
    - MAXGEN if max_gens != 0 and next gen_count == max_gens.
    - STALL if stall_limit != 0 and next stall_count >= stall_limit.
  - If any check fires: stop_reason <= code and state -> DONE on the same edge, so done rises the cycle after the gen_done pulse.
- RUN, other inputs:
  - start is ignored.
  - gen_done=0: counters and result hold.
- DONE:
  - done=1; all outputs hold; gen_done is ignored.
  - start -> CLEAR (restart).
- Limits are sampled live; software holds them stable during RUN.
- reset asserted mid-run: immediate return to reset values, no clear_best pulse.
- Latency:
  - start -> clear_best: 1 cycle.
  - start -> running: 2 cycles.
  - gen_done -> updated outputs/done: 1 cycle.

Optional Feature:
- Macro GA_STOP_ABORT_EN.
- When defined:
  - Adds input abort (1 bit).
  - abort=1 in RUN -> DONE with stop_reason ABORT, with priority over gen_done in the same cycle; that generation is not counted.
  - abort is ignored outside RUN.
- When undefined: no abort port exists, and code 4 is never produced.

Decomposition:
- Shared package ga_pkg:
  - stop_reason_e enum (3-bit codes above).
  - ga_stop_state_e enum (IDLE, CLEAR, RUN, DONE).
  - Default width constants FITNESS_WIDTH_D=27, CHROM_WIDTH_D=8.
- One sub-module, sat_counter (parameterised WIDTH; clear/increment/saturate), instantiated for gen_count and stall_count.

Test Plan:
- Reset then start -> clear_best pulses 1 cycle in CLEAR; running=1 from the second cycle; result_fit=0x7FFFFFF.
- target_fit=100; gen_done with best_fit 500, 300, 90 -> after the third: done=1, stop_reason=1, gen_count=3, result_fit=90.
- max_gens=4, stall_limit=0, target_fit=0; best_fit 50, 40, 40, 30 -> done after the 4th, stop_reason=2, result_fit=30, stall_count=0.
- stall_limit=2; best_fit 70, 70, 70 -> stall_count 0, 1, 2; done with stop_reason=3, result_fit=70.
- Simultaneous: max_gens=1 and best_fit<=target_fit on the first gen_done -> stop_reason=1 (TARGET wins).
- Reset deasserted-then-asserted mid-RUN at gen_count=5 -> all outputs return to reset values asynchronously; start in DONE restarts with gen_count=0; with GA_STOP_ABORT_EN, abort together with gen_done -> stop_reason=4 and gen_count unchanged.
